// File: rtl/edubos5_lsu_pkg.sv
// Shared types and helpers for the edubos5 load/store unit: state encoding,
// byte-enable codes, funct3 encodings and alignment/extension functions.
package edubos5_pkg;

    typedef logic [31:0] cpu_addr_t;
    typedef logic [31:0] cpu_data_t;

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        RESP
    } lsu_state_t;

    typedef enum logic [3:0] {
        NOWR      = 4'b0000,
        BYTE1     = 4'b0001,
        BYTE2     = 4'b0010,
        BYTE3     = 4'b0100,
        BYTE4     = 4'b1000,
        HALFWORD1 = 4'b0011,
        HALFWORD2 = 4'b1100,
        WORD      = 4'b1111
    } we_bs_t;

    typedef enum logic [2:0] {
        LB  = 3'b000,
        LH  = 3'b001,
        LW  = 3'b010,
        LBU = 3'b100,
        LHU = 3'b101
    } funct3_load_t;

    typedef enum logic [2:0] {
        SB = 3'b000,
        SH = 3'b001,
        SW = 3'b010
    } funct3_store_t;

    // True when funct3 is legal for the access kind and the address is naturally aligned.
    function automatic logic access_ok(logic is_store, logic [2:0] f3, logic [1:0] lo);
        logic ok;
        ok = 1'b0;
        if (is_store) begin
            case (funct3_store_t'(f3))
                SB:      ok = 1'b1;
                SH:      ok = ~lo[0];
                SW:      ok = (lo == 2'b00);
                default: ok = 1'b0;
            endcase
        end else begin
            case (funct3_load_t'(f3))
                LB, LBU: ok = 1'b1;
                LH, LHU: ok = ~lo[0];
                LW:      ok = (lo == 2'b00);
                default: ok = 1'b0;
            endcase
        end
        return ok;
    endfunction

    function automatic we_bs_t store_be(logic [2:0] f3, logic [1:0] lo);
        we_bs_t be;
        be = NOWR;
        case (funct3_store_t'(f3))
            SB: begin
                case (lo)
                    2'd0:    be = BYTE1;
                    2'd1:    be = BYTE2;
                    2'd2:    be = BYTE3;
                    default: be = BYTE4;
                endcase
            end
            SH:      be = lo[1] ? HALFWORD2 : HALFWORD1;
            SW:      be = WORD;
            default: be = NOWR;
        endcase
        return be;
    endfunction

    function automatic cpu_data_t store_data(logic [2:0] f3, cpu_data_t w);
        cpu_data_t d;
        d = '0;
        case (funct3_store_t'(f3))
            SB:      d = {4{w[7:0]}};
            SH:      d = {2{w[15:0]}};
            SW:      d = w;
            default: d = '0;
        endcase
        return d;
    endfunction

    function automatic cpu_data_t load_extend(logic [2:0] f3, logic [1:0] lo, cpu_data_t w);
        logic [7:0]  b;
        logic [15:0] h;
        cpu_data_t   d;
        b = 8'(w >> {lo, 3'b000});
        h = 16'(w >> {lo[1], 4'b0000});
        d = '0;
        case (funct3_load_t'(f3))
            LB:      d = {{24{b[7]}}, b};
            LBU:     d = {24'd0, b};
            LH:      d = {{16{h[15]}}, h};
            LHU:     d = {16'd0, h};
            LW:      d = w;
            default: d = '0;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/edubos5_lsu_if.sv
// Execute-stage request/response and data-memory bus of the LSU.
// slave = LSU side, master = core/memory side.
interface edubos5_lsu_if;
    import edubos5_pkg::*;

    logic      req_valid;
    logic      req_ready;
    logic      req_is_store;
    logic [2:0] req_funct3;
    cpu_addr_t req_addr;
    cpu_data_t req_wdata;

    logic      rsp_valid;
    cpu_data_t rsp_rdata;
    logic      rsp_err;

    logic      mem_req;
    we_bs_t    mem_we;
    cpu_addr_t mem_addr;
    cpu_data_t mem_wdata;
    logic      mem_ack;
    cpu_data_t mem_rdata;

    modport slave (
        input  req_valid, req_is_store, req_funct3, req_addr, req_wdata,
        output req_ready,
        output rsp_valid, rsp_rdata, rsp_err,
        output mem_req, mem_we, mem_addr, mem_wdata,
        input  mem_ack, mem_rdata
    );

    modport master (
        output req_valid, req_is_store, req_funct3, req_addr, req_wdata,
        input  req_ready,
        input  rsp_valid, rsp_rdata, rsp_err,
        input  mem_req, mem_we, mem_addr, mem_wdata,
        output mem_ack, mem_rdata
    );

endinterface

// File: rtl/edubos5_lsu_ldext.sv
// Combinational load-data extraction: picks byte/halfword by address and extends.
module edubos5_lsu_ldext
    import edubos5_pkg::*;
(
    input  logic [2:0] funct3,
    input  logic [1:0] addr_lo,
    input  cpu_data_t  mem_word,
    output cpu_data_t  data
);

    assign data = load_extend(funct3, addr_lo, mem_word);

endmodule

// File: rtl/edubos5_lsu.sv
// Single-outstanding load/store unit: IDLE -> ACCESS -> RESP, with early error
// response for misaligned/illegal requests and a memory-ack timeout.
module edubos5_lsu
    import edubos5_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYC = 255
) (
    input logic         clk,
    input logic         arst_n,
    edubos5_lsu_if.slave bus
);

    localparam int unsigned CNT_W = (TIMEOUT_CYC < 1) ? 1 : $clog2(TIMEOUT_CYC + 1);

    lsu_state_t       state;
    lsu_state_t       state_next;
    logic [CNT_W-1:0] cnt;
    logic             is_store_q;
    logic [2:0]       funct3_q;
    logic [1:0]       addr_lo_q;
    we_bs_t           mem_we_q;
    cpu_addr_t        mem_addr_q;
    cpu_data_t        mem_wdata_q;
    cpu_data_t        rsp_rdata_q;
    logic             rsp_err_q;
    cpu_data_t        ld_data;
    logic             req_ok;
    logic             expired;

    assign req_ok  = access_ok(bus.req_is_store, bus.req_funct3, bus.req_addr[1:0]);
    assign expired = (cnt == '0);

    assign bus.mem_we    = mem_we_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign bus.rsp_rdata = rsp_rdata_q;
    assign bus.rsp_err   = rsp_err_q;

    edubos5_lsu_ldext u_ldext (
        .funct3   (funct3_q),
        .addr_lo  (addr_lo_q),
        .mem_word (bus.mem_rdata),
        .data     (ld_data)
    );

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next    = state;
        bus.req_ready = 1'b0;
        bus.mem_req   = 1'b0;
        bus.rsp_valid = 1'b0;
        case (state)
            IDLE: begin
                bus.req_ready = 1'b1;
                if (bus.req_valid) begin
                    state_next = req_ok ? ACCESS : RESP;
                end
            end
            ACCESS: begin
                bus.mem_req = 1'b1;
                // an ack in the expiry cycle still wins; rsp_err is decided in the datapath
                if (bus.mem_ack || expired) begin
                    state_next = RESP;
                end
            end
            RESP: begin
                bus.rsp_valid = 1'b1;
                state_next    = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            cnt         <= '0;
            is_store_q  <= 1'b0;
            funct3_q    <= '0;
            addr_lo_q   <= '0;
            mem_we_q    <= NOWR;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.req_valid) begin
                        is_store_q <= bus.req_is_store;
                        funct3_q   <= bus.req_funct3;
                        addr_lo_q  <= bus.req_addr[1:0];
                        if (req_ok) begin
                            mem_we_q    <= bus.req_is_store ? store_be(bus.req_funct3, bus.req_addr[1:0]) : NOWR;
                            mem_addr_q  <= {bus.req_addr[31:2], 2'b00};
                            mem_wdata_q <= bus.req_is_store ? store_data(bus.req_funct3, bus.req_wdata) : '0;
                            cnt         <= CNT_W'(TIMEOUT_CYC);
                        end else begin
                            rsp_err_q   <= 1'b1;
                            rsp_rdata_q <= '0;
                        end
                    end
                end
                ACCESS: begin
                    if (bus.mem_ack) begin
                        rsp_err_q   <= 1'b0;
                        rsp_rdata_q <= is_store_q ? '0 : ld_data;
                    end else if (expired) begin
                        rsp_err_q   <= 1'b1;
                        rsp_rdata_q <= '0;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_edubos5_lsu.sv
// Scoreboard bench for edubos5_lsu: expected responses are queued at request
// time and compared when rsp_valid is seen.
module tb_edubos5_lsu;
    import edubos5_pkg::*;

    localparam int unsigned TMO = 4;

    typedef struct packed {
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    logic clk    = 1'b0;
    logic arst_n = 1'b0;
    int   n_checks = 0;
    int   n_fail   = 0;
    exp_t sb[$];

    edubos5_lsu_if bus();

    edubos5_lsu #(.TIMEOUT_CYC(TMO)) dut (
        .clk    (clk),
        .arst_n (arst_n),
        .bus    (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.req_valid    = 1'b0;
        bus.req_is_store = 1'b0;
        bus.req_funct3   = 3'b000;
        bus.req_addr     = 32'h0;
        bus.req_wdata    = 32'h0;
        bus.mem_ack      = 1'b0;
        bus.mem_rdata    = 32'h0;
    endtask

    function automatic exp_t pop_exp();
        exp_t e;
        e.rdata = 'x;
        e.err   = 1'bx;
        if (sb.size() != 0) e = sb.pop_front();
        return e;
    endfunction

    function automatic logic [103:0] out_vec();
        return {bus.req_ready, bus.rsp_valid, bus.rsp_err, bus.mem_req, 4'(bus.mem_we),
                bus.rsp_rdata, bus.mem_addr, bus.mem_wdata};
    endfunction

    // Presents one request for a single cycle; the caller must be in IDLE.
    task automatic issue(input logic st, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] wd, input logic [31:0] er, input logic ee);
        exp_t e;
        bus.req_valid    = 1'b1;
        bus.req_is_store = st;
        bus.req_funct3   = f3;
        bus.req_addr     = a;
        bus.req_wdata    = wd;
        e.rdata = er;
        e.err   = ee;
        sb.push_back(e);
        tick();
        bus.req_valid = 1'b0;
    endtask

    task automatic test_reset();
        logic [103:0] rv;
        idle_inputs();
        arst_n = 1'b0;
        #12;
        rv = {1'b1, 103'd0};
        n_checks++;
        if (out_vec() !== rv) begin
            n_fail++;
            $display("FAIL reset_state: got %h expected %h", out_vec(), rv);
        end
        @(negedge clk);
        arst_n = 1'b1;
        tick();
        n_checks++;
        if (out_vec() !== rv) begin
            n_fail++;
            $display("FAIL reset_release: got %h expected %h", out_vec(), rv);
        end
    endtask

    task automatic test_store_byte();
        exp_t e;
        issue(1'b1, 3'b000, 32'h0000_0102, 32'h0000_00A5, 32'h0, 1'b0);
        n_checks++;
        if (bus.mem_req !== 1'b1 || bus.req_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL sb_mem_req: got req=%b ready=%b expected req=1 ready=0", bus.mem_req, bus.req_ready);
        end
        n_checks++;
        if (bus.mem_we !== 4'b0100 || bus.mem_addr !== 32'h100 || bus.mem_wdata !== 32'hA5A5_A5A5) begin
            n_fail++;
            $display("FAIL sb_mem_bus: got we=%b addr=%h wdata=%h expected we=0100 addr=00000100 wdata=a5a5a5a5",
                     bus.mem_we, bus.mem_addr, bus.mem_wdata);
        end
        bus.mem_ack = 1'b1;
        tick();
        bus.mem_ack = 1'b0;
        n_checks++;
        if (bus.rsp_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL sb_latency: got rsp_valid=%b expected 1 at N+2", bus.rsp_valid);
        end
        e = pop_exp();
        n_checks++;
        if (bus.rsp_rdata !== e.rdata || bus.rsp_err !== e.err) begin
            n_fail++;
            $display("FAIL sb_rsp: got rdata=%h err=%b expected rdata=%h err=%b", bus.rsp_rdata, bus.rsp_err, e.rdata, e.err);
        end
        tick();
        n_checks++;
        if (bus.rsp_valid !== 1'b0 || bus.req_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL sb_pulse: got rsp_valid=%b ready=%b expected 0 and 1", bus.rsp_valid, bus.req_ready);
        end
    endtask

    task automatic test_store_lanes();
        logic [2:0]  f3 [6];
        logic [31:0] ad [6];
        logic [31:0] wd [6];
        logic [3:0]  we [6];
        logic [31:0] md [6];
        exp_t e;
        f3 = '{3'd0, 3'd0, 3'd0, 3'd1, 3'd1, 3'd2};
        ad = '{32'h10, 32'h11, 32'h13, 32'h20, 32'h22, 32'h30};
        wd = '{32'h11223344, 32'h11223344, 32'h11223344, 32'hAABBCCDD, 32'hAABBCCDD, 32'hDEADBEEF};
        we = '{4'b0001, 4'b0010, 4'b1000, 4'b0011, 4'b1100, 4'b1111};
        md = '{32'h44444444, 32'h44444444, 32'h44444444, 32'hCCDDCCDD, 32'hCCDDCCDD, 32'hDEADBEEF};
        for (int i = 0; i < 6; i++) begin
            bus.mem_rdata = 32'hFFFF_FFFF;
            issue(1'b1, f3[i], ad[i], wd[i], 32'h0, 1'b0);
            n_checks++;
            if (bus.mem_we !== we[i] || bus.mem_addr !== (ad[i] & 32'hFFFF_FFFC) || bus.mem_wdata !== md[i]) begin
                n_fail++;
                $display("FAIL store_lane[%0d]: got we=%b addr=%h wdata=%h expected we=%b addr=%h wdata=%h",
                         i, bus.mem_we, bus.mem_addr, bus.mem_wdata, we[i], ad[i] & 32'hFFFF_FFFC, md[i]);
            end
            bus.mem_ack = 1'b1;
            tick();
            bus.mem_ack = 1'b0;
            e = pop_exp();
            n_checks++;
            if (bus.rsp_valid !== 1'b1 || bus.rsp_rdata !== e.rdata || bus.rsp_err !== e.err) begin
                n_fail++;
                $display("FAIL store_rsp[%0d]: got valid=%b rdata=%h err=%b expected valid=1 rdata=%h err=%b",
                         i, bus.rsp_valid, bus.rsp_rdata, bus.rsp_err, e.rdata, e.err);
            end
            tick();
        end
    endtask

    task automatic test_load_ext();
        logic [2:0]  f3 [10];
        logic [31:0] ad [10];
        logic [31:0] rd [10];
        logic [31:0] ex [10];
        exp_t e;
        f3 = '{3'b000, 3'b100, 3'b000, 3'b100, 3'b001, 3'b101, 3'b000, 3'b001, 3'b010, 3'b100};
        ad = '{32'h203, 32'h203, 32'h202, 32'h202, 32'h202, 32'h202, 32'h200, 32'h200, 32'h200, 32'h201};
        rd = '{32'h80FF0000, 32'h80FF0000, 32'h80FF0000, 32'h80FF0000, 32'h80FF0000,
               32'h80FF0000, 32'h12348765, 32'h12348765, 32'h12348765, 32'h12348765};
        ex = '{32'hFFFFFF80, 32'h00000080, 32'hFFFFFFFF, 32'h000000FF, 32'hFFFF80FF,
               32'h000080FF, 32'h00000065, 32'hFFFF8765, 32'h12348765, 32'h00000087};
        for (int i = 0; i < 10; i++) begin
            bus.mem_rdata = 32'h5555_5555;
            issue(1'b0, f3[i], ad[i], 32'hFFFF_FFFF, ex[i], 1'b0);
            for (int w = 0; w < i % 3; w++) begin
                n_checks++;
                if (bus.mem_req !== 1'b1 || bus.mem_addr !== 32'h200) begin
                    n_fail++;
                    $display("FAIL load_hold[%0d]: got req=%b addr=%h expected req=1 addr=00000200", i, bus.mem_req, bus.mem_addr);
                end
                tick();
            end
            n_checks++;
            if (bus.mem_req !== 1'b1 || bus.mem_we !== 4'b0000 || bus.mem_addr !== 32'h200) begin
                n_fail++;
                $display("FAIL load_bus[%0d]: got req=%b we=%b addr=%h expected req=1 we=0000 addr=00000200",
                         i, bus.mem_req, bus.mem_we, bus.mem_addr);
            end
            bus.mem_ack   = 1'b1;
            bus.mem_rdata = rd[i];
            tick();
            bus.mem_ack   = 1'b0;
            bus.mem_rdata = 32'hDEAD_DEAD;
            e = pop_exp();
            n_checks++;
            if (bus.rsp_valid !== 1'b1 || bus.rsp_rdata !== e.rdata || bus.rsp_err !== e.err) begin
                n_fail++;
                $display("FAIL load_rsp[%0d]: got valid=%b rdata=%h err=%b expected valid=1 rdata=%h err=%b",
                         i, bus.rsp_valid, bus.rsp_rdata, bus.rsp_err, e.rdata, e.err);
            end
            tick();
        end
    endtask

    task automatic test_misaligned();
        logic        st [8];
        logic [2:0]  f3 [8];
        logic [31:0] ad [8];
        exp_t e;
        st = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
        f3 = '{3'b001, 3'b101, 3'b010, 3'b001, 3'b010, 3'b011, 3'b110, 3'b100};
        ad = '{32'h001, 32'h003, 32'h002, 32'h005, 32'h003, 32'h000, 32'h000, 32'h000};
        for (int i = 0; i < 8; i++) begin
            issue(st[i], f3[i], ad[i], 32'h1234_5678, 32'h0, 1'b1);
            e = pop_exp();
            n_checks++;
            if (bus.rsp_valid !== 1'b1 || bus.mem_req !== 1'b0 || bus.rsp_rdata !== e.rdata || bus.rsp_err !== e.err) begin
                n_fail++;
                $display("FAIL err_rsp[%0d]: got valid=%b mem_req=%b rdata=%h err=%b expected valid=1 mem_req=0 rdata=%h err=%b",
                         i, bus.rsp_valid, bus.mem_req, bus.rsp_rdata, bus.rsp_err, e.rdata, e.err);
            end
            tick();
            n_checks++;
            if (bus.rsp_valid !== 1'b0 || bus.mem_req !== 1'b0) begin
                n_fail++;
                $display("FAIL err_after[%0d]: got valid=%b mem_req=%b expected 0 0", i, bus.rsp_valid, bus.mem_req);
            end
        end
    endtask

    task automatic test_timeout();
        int   hi;
        int   cyc;
        exp_t e;
        issue(1'b0, 3'b010, 32'h40, 32'h0, 32'h0, 1'b1);
        hi  = 0;
        cyc = 0;
        while (bus.rsp_valid !== 1'b1 && cyc < 20) begin
            if (bus.mem_req === 1'b1) hi++;
            tick();
            cyc++;
        end
        n_checks++;
        if (bus.rsp_valid !== 1'b1 || hi != int'(TMO + 1)) begin
            n_fail++;
            $display("FAIL timeout_req_cycles: got valid=%b mem_req_cycles=%0d expected valid=1 cycles=%0d",
                     bus.rsp_valid, hi, TMO + 1);
        end
        e = pop_exp();
        n_checks++;
        if (bus.rsp_rdata !== e.rdata || bus.rsp_err !== e.err) begin
            n_fail++;
            $display("FAIL timeout_rsp: got rdata=%h err=%b expected rdata=%h err=%b", bus.rsp_rdata, bus.rsp_err, e.rdata, e.err);
        end
        tick();
        issue(1'b0, 3'b010, 32'h44, 32'h0, 32'hCAFE_F00D, 1'b0);
        repeat (TMO) tick();
        n_checks++;
        if (bus.mem_req !== 1'b1) begin
            n_fail++;
            $display("FAIL timeout_last_cycle: got mem_req=%b expected 1", bus.mem_req);
        end
        bus.mem_ack   = 1'b1;
        bus.mem_rdata = 32'hCAFE_F00D;
        tick();
        bus.mem_ack = 1'b0;
        e = pop_exp();
        n_checks++;
        if (bus.rsp_valid !== 1'b1 || bus.rsp_rdata !== e.rdata || bus.rsp_err !== e.err) begin
            n_fail++;
            $display("FAIL ack_at_expiry: got valid=%b rdata=%h err=%b expected valid=1 rdata=%h err=%b",
                     bus.rsp_valid, bus.rsp_rdata, bus.rsp_err, e.rdata, e.err);
        end
        tick();
    endtask

    task automatic test_reset_mid_access();
        logic [103:0] rv;
        int           seen;
        exp_t         e;
        issue(1'b1, 3'b010, 32'h80, 32'h7777_8888, 32'h0, 1'b0);
        tick();
        #2;
        arst_n = 1'b0;
        #1;
        rv = {1'b1, 103'd0};
        n_checks++;
        if (out_vec() !== rv) begin
            n_fail++;
            $display("FAIL reset_mid_access: got %h expected %h", out_vec(), rv);
        end
        sb.delete();
        @(negedge clk);
        arst_n      = 1'b1;
        bus.mem_ack = 1'b1;
        seen = 0;
        for (int c = 0; c < 4; c++) begin
            tick();
            if (bus.rsp_valid === 1'b1 || bus.mem_req === 1'b1) seen++;
        end
        bus.mem_ack = 1'b0;
        n_checks++;
        if (seen != 0) begin
            n_fail++;
            $display("FAIL reset_abandon: got %0d active cycles after release expected 0", seen);
        end
        issue(1'b0, 3'b010, 32'h84, 32'h0, 32'h5A5A_1234, 1'b0);
        bus.mem_ack   = 1'b1;
        bus.mem_rdata = 32'h5A5A_1234;
        tick();
        bus.mem_ack = 1'b0;
        e = pop_exp();
        n_checks++;
        if (bus.rsp_valid !== 1'b1 || bus.rsp_rdata !== e.rdata || bus.rsp_err !== e.err) begin
            n_fail++;
            $display("FAIL post_reset_lw: got valid=%b rdata=%h err=%b expected valid=1 rdata=%h err=%b",
                     bus.rsp_valid, bus.rsp_rdata, bus.rsp_err, e.rdata, e.err);
        end
        tick();
    endtask

    task automatic test_back_to_back();
        int          nreq;
        int          nrsp;
        logic [31:0] cur_addr;
        exp_t        e;
        exp_t        p;
        bus.mem_ack   = 1'b1;
        bus.mem_rdata = 32'h1234_5678;
        for (int c = 0; c < 2; c++) begin
            tick();
            n_checks++;
            if (bus.rsp_valid !== 1'b0 || bus.mem_req !== 1'b0) begin
                n_fail++;
                $display("FAIL idle_ack[%0d]: got valid=%b mem_req=%b expected 0 0", c, bus.rsp_valid, bus.mem_req);
            end
        end
        nreq     = 0;
        nrsp     = 0;
        cur_addr = 32'h0;
        bus.req_valid    = 1'b1;
        bus.req_is_store = 1'b1;
        bus.req_funct3   = 3'b010;
        for (int c = 0; c < 19; c++) begin
            if (c == 15) bus.req_valid = 1'b0;
            if (bus.mem_req === 1'b1 || bus.rsp_valid === 1'b1) begin
                n_checks++;
                if (bus.req_ready !== 1'b0) begin
                    n_fail++;
                    $display("FAIL b2b_ready[%0d]: got req_ready=%b expected 0", c, bus.req_ready);
                end
            end
            if (bus.mem_req === 1'b1) begin
                n_checks++;
                if (bus.mem_addr !== cur_addr) begin
                    n_fail++;
                    $display("FAIL b2b_addr[%0d]: got %h expected %h", c, bus.mem_addr, cur_addr);
                end
            end
            if (bus.rsp_valid === 1'b1) begin
                nrsp++;
                e = pop_exp();
                n_checks++;
                if (bus.rsp_rdata !== e.rdata || bus.rsp_err !== e.err) begin
                    n_fail++;
                    $display("FAIL b2b_rsp[%0d]: got rdata=%h err=%b expected rdata=%h err=%b",
                             c, bus.rsp_rdata, bus.rsp_err, e.rdata, e.err);
                end
            end
            if (bus.req_ready === 1'b1 && bus.req_valid === 1'b1) begin
                cur_addr      = 32'h300 + 32'(4 * nreq);
                bus.req_addr  = cur_addr;
                bus.req_wdata = 32'hA000_0000 + 32'(nreq);
                p.rdata = 32'h0;
                p.err   = 1'b0;
                sb.push_back(p);
                nreq++;
            end
            tick();
        end
        bus.mem_ack = 1'b0;
        n_checks++;
        if (nreq != 5 || nrsp != nreq) begin
            n_fail++;
            $display("FAIL b2b_count: got requests=%0d responses=%0d expected 5 and 5", nreq, nrsp);
        end
    endtask

    initial begin
        idle_inputs();
        test_reset();
        test_store_byte();
        test_store_lanes();
        test_load_ext();
        test_misaligned();
        test_timeout();
        test_reset_mid_access();
        test_back_to_back();
        n_checks++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no completion expected finish before time limit");
        $fatal(1, "watchdog expired");
    end

endmodule
